// File: rtl/pipeline_step_ctrl_pkg.sv
// rtl/pipeline_step_ctrl_pkg.sv - shared encodings for the pipeline single-step controller
package pipeline_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_PAUSE = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  // The pipeline is frozen whenever the controller is parked.
  function automatic logic is_frozen(state_t s);
    return (s == ST_IDLE) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// rtl/pipeline_step_ctrl_if.sv - debug command handshake between host and step controller
interface pipeline_step_ctrl_if;
  import pipeline_step_ctrl_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pipeline_step_ctrl_sat_counter.sv
// rtl/pipeline_step_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// rtl/pipeline_step_ctrl.sv - run/step/pause/halt debug controller freezing the pipeline
// Optional breakpoint compare compiled in with PIPELINE_STEP_CTRL_BREAKPOINT_EN.
module pipeline_step_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_step_ctrl_if.slave cmd,
  input  logic [STEP_W-1:0]   step_len,
  input  logic                prog_end,
  input  logic                bp_wr,
  input  logic [31:0]         bp_wdata,
  input  logic [31:0]         pc_exe,
  output logic                stop_debug,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    run_cycles,
  output logic                done,
  output logic                bp_hit
);
  import pipeline_step_ctrl_pkg::*;

  state_t            cur_state;
  state_t            nxt_state;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] nxt_step_cnt;
  logic              nxt_done;
  logic              clr_cycles;
  logic              accept;
  logic              in_flight;

  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign in_flight = (cur_state == ST_RUN) || (cur_state == ST_STEP);
  assign state     = cur_state;

`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_match;
  logic        nxt_bp_hit;

  assign bp_match = bp_valid && (pc_exe == bp_addr);
`else
  logic unused_bp;

  assign unused_bp = ^{bp_wr, bp_wdata, pc_exe};
  assign bp_hit    = 1'b0;
`endif

  // Priority: prog_end, then breakpoint, then step expiry, then host command.
  always_comb begin
    nxt_state    = cur_state;
    nxt_step_cnt = step_cnt;
    nxt_done     = 1'b0;
    clr_cycles   = 1'b0;
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
    nxt_bp_hit   = 1'b0;
`endif
    if (in_flight && prog_end) begin
      nxt_state    = ST_HALTED;
      nxt_step_cnt = '0;
      nxt_done     = 1'b1;
    end
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
    else if ((cur_state == ST_RUN) && bp_match) begin
      nxt_state  = ST_IDLE;
      nxt_bp_hit = 1'b1;
    end
`endif
    else if (cur_state == ST_STEP) begin
      if (step_cnt <= STEP_W'(1)) begin
        nxt_state    = ST_IDLE;
        nxt_step_cnt = '0;
        nxt_done     = 1'b1;
      end else begin
        nxt_step_cnt = step_cnt - STEP_W'(1);
      end
    end else if (accept) begin
      case (cur_state)
        ST_IDLE: begin
          case (cmd_t'(cmd.cmd_code))
            CMD_RUN:   nxt_state = ST_RUN;
            CMD_STEP: begin
              nxt_state    = ST_STEP;
              nxt_step_cnt = (step_len == '0) ? STEP_W'(1) : step_len;
            end
            CMD_CLEAR: clr_cycles = 1'b1;
            default:   nxt_state = ST_IDLE;
          endcase
        end
        ST_RUN: begin
          case (cmd_t'(cmd.cmd_code))
            CMD_PAUSE: nxt_state = ST_IDLE;
            CMD_CLEAR: clr_cycles = 1'b1;
            default:   nxt_state = ST_RUN;
          endcase
        end
        ST_HALTED: begin
          if (cmd_t'(cmd.cmd_code) == CMD_CLEAR) begin
            nxt_state  = ST_IDLE;
            clr_cycles = 1'b1;
          end
        end
        default: nxt_state = cur_state;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state     <= ST_IDLE;
      step_cnt      <= '0;
      stop_debug    <= 1'b1;
      cmd.cmd_ready <= 1'b1;
      done          <= 1'b0;
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
      bp_hit        <= 1'b0;
      bp_addr       <= '0;
      bp_valid      <= 1'b0;
`endif
    end else begin
      cur_state     <= nxt_state;
      step_cnt      <= nxt_step_cnt;
      stop_debug    <= is_frozen(nxt_state);
      cmd.cmd_ready <= (nxt_state != ST_STEP);
      done          <= nxt_done;
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
      bp_hit        <= nxt_bp_hit;
      if (bp_wr) begin
        bp_addr  <= bp_wdata;
        bp_valid <= 1'b1;
      end
`endif
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!stop_debug),
    .clr   (clr_cycles),
    .count (run_cycles)
  );

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// tb/tb_pipeline_step_ctrl.sv - table-driven bench for pipeline_step_ctrl (CNT_W=4)
module tb_pipeline_step_ctrl;

  localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_PAUSE = 2'd2, C_CLR = 2'd3;
  localparam logic [1:0] S_I = 2'd0, S_R = 2'd1, S_S = 2'd2, S_H = 2'd3;

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic [1:0] code;
    logic [7:0] len;
    logic       pe;
    logic [1:0] e_state;
    logic       e_sd;
    logic       e_rdy;
    logic       e_done;
    logic [3:0] e_rc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  step_len;
  logic        prog_end;
  logic        bp_wr;
  logic [31:0] bp_wdata;
  logic [31:0] pc_exe;
  logic        stop_debug;
  logic [1:0]  state;
  logic [3:0]  run_cycles;
  logic        done;
  logic        bp_hit;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  pipeline_step_ctrl_if cmd_if ();

  pipeline_step_ctrl #(
    .CNT_W  (4),
    .STEP_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .step_len   (step_len),
    .prog_end   (prog_end),
    .bp_wr      (bp_wr),
    .bp_wdata   (bp_wdata),
    .pc_exe     (pc_exe),
    .stop_debug (stop_debug),
    .state      (state),
    .run_cycles (run_cycles),
    .done       (done),
    .bp_hit     (bp_hit)
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic r, input logic v, input logic [1:0] c,
                     input logic [7:0] l, input logic p, input logic [1:0] es,
                     input logic esd, input logic erdy, input logic edone, input logic [3:0] erc);
    vecs.push_back('{n, r, v, c, l, p, es, esd, erdy, edone, erc});
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] c,
                       input logic [7:0] l, input logic p);
    rst              = r;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_code  = c;
    step_len         = l;
    prog_end         = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_if.cmd_valid = 1'b0; cmd_if.cmd_code = 2'd0;
    step_len = 8'd0; prog_end = 1'b0; bp_wr = 1'b0; bp_wdata = 32'd0; pc_exe = 32'd0;

    add("reset",          0, 0, 0,       0, 0, S_I, 1, 1, 0, 0);
    add("idle",           1, 0, 0,       0, 0, S_I, 1, 1, 0, 0);
    add("run",            1, 1, C_RUN,   0, 0, S_R, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++)
      add("running",      1, 0, 0,       0, 0, S_R, 0, 1, 0, 4'(i));
    add("pause",          1, 1, C_PAUSE, 0, 0, S_I, 1, 1, 0, 10);
    add("paused_hold",    1, 0, 0,       0, 0, S_I, 1, 1, 0, 10);
    add("idle_clear",     1, 1, C_CLR,   0, 0, S_I, 1, 1, 0, 0);
    add("step3_a",        1, 1, C_STEP,  3, 0, S_S, 0, 0, 0, 0);
    add("step3_b_block",  1, 1, C_PAUSE, 0, 0, S_S, 0, 0, 0, 1);
    add("step3_c",        1, 0, 0,       0, 0, S_S, 0, 0, 0, 2);
    add("step3_done",     1, 0, 0,       0, 0, S_I, 1, 1, 1, 3);
    add("step3_after",    1, 0, 0,       0, 0, S_I, 1, 1, 0, 3);
    add("step0_a",        1, 1, C_STEP,  0, 0, S_S, 0, 0, 0, 3);
    add("step0_done",     1, 0, 0,       0, 0, S_I, 1, 1, 1, 4);
    add("step0_after",    1, 0, 0,       0, 0, S_I, 1, 1, 0, 4);
    add("run2",           1, 1, C_RUN,   0, 0, S_R, 0, 1, 0, 4);
    add("run_step_ign",   1, 1, C_STEP,  3, 0, S_R, 0, 1, 0, 5);
    add("run_run_ign",    1, 1, C_RUN,   0, 0, S_R, 0, 1, 0, 6);
    add("run_clear",      1, 1, C_CLR,   0, 0, S_R, 0, 1, 0, 0);
    add("run_more",       1, 0, 0,       0, 0, S_R, 0, 1, 0, 1);
    add("halt_pe_pause",  1, 1, C_PAUSE, 0, 1, S_H, 1, 1, 1, 2);
    add("halted_hold",    1, 0, 0,       0, 0, S_H, 1, 1, 0, 2);
    add("halted_run_ign", 1, 1, C_RUN,   0, 0, S_H, 1, 1, 0, 2);
    add("halted_stp_ign", 1, 1, C_STEP,  2, 0, S_H, 1, 1, 0, 2);
    add("halted_pe_ign",  1, 0, 0,       0, 1, S_H, 1, 1, 0, 2);
    add("halted_clear",   1, 1, C_CLR,   0, 0, S_I, 1, 1, 0, 0);
    add("idle_pe_ign",    1, 0, 0,       0, 1, S_I, 1, 1, 0, 0);
    add("step5_a",        1, 1, C_STEP,  5, 0, S_S, 0, 0, 0, 0);
    add("step5_pe",       1, 0, 0,       0, 1, S_H, 1, 1, 1, 1);
    add("clear2",         1, 1, C_CLR,   0, 0, S_I, 1, 1, 0, 0);
    add("step2_a",        1, 1, C_STEP,  2, 0, S_S, 0, 0, 0, 0);
    add("step2_b",        1, 0, 0,       0, 0, S_S, 0, 0, 0, 1);
    add("step2_pe_exp",   1, 0, 0,       0, 1, S_H, 1, 1, 1, 2);
    add("clear3",         1, 1, C_CLR,   0, 0, S_I, 1, 1, 0, 0);
    add("idle_pause",     1, 1, C_PAUSE, 0, 0, S_I, 1, 1, 0, 0);
    add("run3",           1, 1, C_RUN,   0, 0, S_R, 0, 1, 0, 0);
    add("run3_b",         1, 0, 0,       0, 0, S_R, 0, 1, 0, 1);
    add("rst_mid_run",    0, 0, 0,       0, 0, S_I, 1, 1, 0, 0);
    add("after_rst",      1, 0, 0,       0, 0, S_I, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].code, vecs[i].len, vecs[i].pe);
      chk(vecs[i].name, {22'd0, state, stop_debug, cmd_if.cmd_ready, done, bp_hit, run_cycles},
          {22'd0, vecs[i].e_state, vecs[i].e_sd, vecs[i].e_rdy, vecs[i].e_done, 1'b0, vecs[i].e_rc});
    end

    // Saturation of the 4-bit run counter over 20 unfrozen cycles.
    drive(1, 1, C_RUN, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
    chk("sat_count", 32'(run_cycles), 32'd15);
    chk("sat_state", 32'(state), 32'(S_R));

    // Reset in the middle of a step: no done pulse, operation abandoned.
    drive(1, 1, C_PAUSE, 0, 0);
    drive(1, 1, C_CLR, 0, 0);
    drive(1, 1, C_STEP, 5, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_step", {29'd0, state, done}, {29'd0, S_I, 1'b0});
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        drive(1, 0, 0, 0, 0);
        if (done || !stop_debug) seen++;
      end
      chk("rst_step_no_done", 32'(seen), 32'd0);
    end

    // Breakpoint during RUN.
    drive(0, 0, 0, 0, 0);
    bp_wr = 1'b1; bp_wdata = 32'h40;
    drive(1, 0, 0, 0, 0);
    bp_wr = 1'b0; pc_exe = 32'h0;
    drive(1, 1, C_RUN, 0, 0);
    pc_exe = 32'h40;
    drive(1, 0, 0, 0, 0);
`ifdef PIPELINE_STEP_CTRL_BREAKPOINT_EN
    chk("bp_hit", {29'd0, state, bp_hit}, {29'd0, S_I, 1'b1});
    chk("bp_freeze", 32'(stop_debug), 32'd1);
`else
    chk("bp_off", {29'd0, state, bp_hit}, {29'd0, S_R, 1'b0});
    chk("bp_off_run", 32'(stop_debug), 32'd0);
`endif
    drive(1, 0, 0, 0, 0);
    chk("bp_pulse_end", 32'(bp_hit), 32'd0);

    // Breakpoint ignored during STEP; prog_end beats breakpoint.
    drive(0, 0, 0, 0, 0);
    bp_wr = 1'b1; bp_wdata = 32'h40; pc_exe = 32'h40;
    drive(1, 0, 0, 0, 0);
    bp_wr = 1'b0;
    drive(1, 1, C_STEP, 2, 0);
    drive(1, 0, 0, 0, 0);
    chk("bp_step_ign", {28'd0, state, bp_hit, done}, {28'd0, S_S, 1'b0, 1'b0});
    drive(1, 0, 0, 0, 0);
    chk("bp_step_done", {28'd0, state, bp_hit, done}, {28'd0, S_I, 1'b0, 1'b1});
    pc_exe = 32'h0;
    drive(1, 1, C_RUN, 0, 0);
    pc_exe = 32'h40;
    drive(1, 0, 0, 0, 1);
    chk("pe_beats_bp", {28'd0, state, bp_hit, done}, {28'd0, S_H, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_step_ctrl.md
PIPELINE_STEP_CTRL -- requirements
Module: pipeline_step_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the run-cycle counter.
REQ-002 SHALL have parameter STEP_W, default 8, width of the step length.
REQ-003 SHALL have ports: clk  in  1  single clock, posedge-active for this block.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: cmd_valid in 1 command strobe; cmd_code in 2 (00 RUN, 01 STEP, 10 PAUSE, 11 CLEAR); cmd_ready out 1 command accepted when valid&&ready.
REQ-006 SHALL have ports: step_len in STEP_W cycles per STEP; prog_end in 1 HALT instruction retired in WB.
REQ-007 SHALL have ports: bp_wr in 1, bp_wdata in 32 breakpoint load; pc_exe in 32 address of instruction in Execute.
REQ-008 SHALL have ports: stop_debug out 1 pipeline freeze to all stages; state out 2 current state; run_cycles out CNT_W unfrozen cycles; done out 1 one-cycle pulse; bp_hit out 1 one-cycle pulse.

Function
REQ-009 SHALL implement FSM states IDLE=00 (frozen), RUN=01, STEP=10, HALTED=11; stop_debug=1 exactly in IDLE and HALTED, registered from state.
REQ-010 SHALL assert cmd_ready in IDLE, RUN, HALTED; deassert in STEP.
REQ-011 IDLE: RUN->RUN; STEP->STEP loading step counter with step_len (0 treated as 1); PAUSE, CLEAR->IDLE (CLEAR zeroes run_cycles).
REQ-012 RUN: PAUSE->IDLE; STEP/RUN ignored (accepted, no effect); CLEAR zeroes run_cycles, stays RUN.
REQ-013 STEP: decrement counter each cycle; at counter==1 go IDLE next edge with done=1 for one cycle; stop_debug low for exactly max(step_len,1) cycles.
REQ-014 prog_end=1 in RUN or STEP SHALL go HALTED next edge, done=1 one cycle; prog_end ignored in IDLE/HALTED.
REQ-015 HALTED: only CLEAR is acted upon -> IDLE, run_cycles zeroed; RUN/STEP/PAUSE accepted and ignored.
REQ-016 Priority on same edge: reset > prog_end > breakpoint > step expiry > command.
REQ-017 Command latency: accepted at edge k, new state and stop_debug visible after edge k.
REQ-018 run_cycles SHALL increment once per clock with stop_debug=0, saturating at all ones, no wrap.
REQ-019 done and bp_hit SHALL never assert simultaneously; prog_end wins (done only).

Reset
REQ-020 rst=0 sampled at posedge: state=IDLE, stop_debug=1, cmd_ready=1, run_cycles=0, step counter=0, done=0, bp_hit=0, breakpoint register=0 with valid bit cleared.
REQ-021 Reset mid-STEP or mid-RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-022 Macro PIPELINE_STEP_CTRL_BREAKPOINT_EN SHALL compile in breakpoint logic: bp_wr loads bp_wdata and sets valid; in RUN, valid && pc_exe==breakpoint -> IDLE next edge, bp_hit one cycle; in STEP, breakpoint ignored.
REQ-023 Without the macro: bp_wr, bp_wdata, pc_exe unused; bp_hit tied 0; no breakpoint register.

Structure
REQ-024 Shared package SHALL hold state encodings and cmd_code constants (RUN, STEP, PAUSE, CLEAR).
REQ-025 Saturating counter SHALL be sub-module sat_counter (parameter width, inputs clk, rst, en, clr; output count).
REQ-026 All state in one posedge clocked process; next-state logic combinational.

Verification
REQ-027 Reset then RUN at cycle 2, PAUSE at cycle 12 -> stop_debug low cycles 3-12, run_cycles=10, state=IDLE.
REQ-028 STEP with step_len=3 -> stop_debug low exactly 3 cycles, cmd_ready=0 those cycles, done pulse once, state IDLE.
REQ-029 STEP with step_len=0 -> one unfrozen cycle, done pulse.
REQ-030 RUN, prog_end and PAUSE same cycle -> HALTED, done=1; later RUN ignored; CLEAR -> IDLE, run_cycles=0.
REQ-031 With macro: bp_wdata=0x40, RUN, pc_exe=0x40 -> IDLE next edge, bp_hit=1; without macro same stimulus -> stays RUN, bp_hit=0.
REQ-032 CNT_W=4, RUN 20 cycles -> run_cycles holds 15; rst=0 during STEP -> IDLE, no done.
